// File: rtl/operand_issue_pkg.sv
// Shared types and constants for the operand issue stage.
//   WIDTH  : data word width
//   NREGS  : register file depth
//   RADDR  : register index width
//   inst_t : instruction word layout {opcode, dest, src}
//   issue_state_e : output-register occupancy
package operand_issue_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 64;
  localparam int RADDR = 6;
  localparam int OPW   = 5;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [RADDR-1:0] dest;
    logic [RADDR-1:0] src;
  } inst_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } issue_state_e;

  function automatic inst_t decode(input logic [WIDTH-1:0] word);
    inst_t d;
    d.opcode = word[15:12];
    d.dest   = word[11:6];
    d.src    = word[5:0];
    return d;
  endfunction

endpackage

// File: rtl/operand_issue_regfile_2r1w.sv
// 64x16 register file: two asynchronous read ports, one write port.
// A write in progress is forwarded to either read port addressing the same
// entry, so readers see the value that will be stored at the next edge.
//   clk, reset          : clock, async active-high clear of all entries
//   we, waddr, wdata    : write port
//   raddr1/2, rdata1/2  : read ports (combinational, with write bypass)
module regfile_2r1w
  import operand_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RADDR-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RADDR-1:0] raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [RADDR-1:0] raddr2,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = (we && (waddr == raddr1)) ? wdata : mem_q[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : mem_q[raddr2];

endmodule

// File: rtl/operand_issue.sv
// Decode / operand-fetch stage feeding the combinational ALU.
// Decodes {opcode, dest, src}, reads both operands from the register file
// and holds {op, in1, in2, dest} in an output register with a valid/ready
// handshake. A per-register busy scoreboard stalls read-after-write hazards;
// ALU writebacks clear busy bits and update the register file.
//   clk, reset                      : clock, async active-high reset
//   inst, inst_valid, inst_ready    : instruction input handshake
//   out_op/in1/in2/dest, out_valid,
//   out_ready                       : issued instruction to execute stage
//   wb_en, wb_dest, wb_data         : ALU writeback
//
// state | meaning
// EMPTY | output register holds nothing
// FULL  | output register holds an issued instruction
module operand_issue
  import operand_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inst,
  input  logic             inst_valid,
  output logic             inst_ready,
  output logic [OPW-1:0]   out_op,
  output logic [WIDTH-1:0] out_in1,
  output logic [WIDTH-1:0] out_in2,
  output logic [RADDR-1:0] out_dest,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [WIDTH-1:0] wb_data
);

  issue_state_e     state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [OPW-1:0]   out_op_q, out_op_d;
  logic [WIDTH-1:0] out_in1_q, out_in1_d;
  logic [WIDTH-1:0] out_in2_q, out_in2_d;
  logic [RADDR-1:0] out_dest_q, out_dest_d;

  inst_t            dec;
  logic [WIDTH-1:0] rd_dest, rd_src;
  logic             wb_hit_dest, wb_hit_src;
  logic             hazard, fire;

  assign dec = decode(inst);

  regfile_2r1w u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_dest),
    .wdata  (wb_data),
    .raddr1 (dec.dest),
    .rdata1 (rd_dest),
    .raddr2 (dec.src),
    .rdata2 (rd_src)
  );

  // A writeback landing this cycle already releases its register.
  assign wb_hit_dest = wb_en && (wb_dest == dec.dest);
  assign wb_hit_src  = wb_en && (wb_dest == dec.src);
  assign hazard      = (busy_q[dec.dest] && !wb_hit_dest) ||
                       (busy_q[dec.src]  && !wb_hit_src);

  assign out_valid  = (state_q == FULL);
  assign inst_ready = (!out_valid || out_ready) && !hazard;
  assign fire       = inst_valid && inst_ready;

  always_comb begin
    busy_d     = busy_q;
    state_d    = state_q;
    out_op_d   = out_op_q;
    out_in1_d  = out_in1_q;
    out_in2_d  = out_in2_q;
    out_dest_d = out_dest_q;

    if (wb_en) busy_d[wb_dest] = 1'b0;
    // Issue set is applied after the clear: the new instruction is outstanding.
    if (fire)  busy_d[dec.dest] = 1'b1;

    if (fire) begin
      state_d    = FULL;
      out_op_d   = {1'b0, dec.opcode};
      out_in1_d  = rd_dest;
      out_in2_d  = rd_src;
      out_dest_d = dec.dest;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      busy_q     <= '0;
      out_op_q   <= '0;
      out_in1_q  <= '0;
      out_in2_q  <= '0;
      out_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      out_op_q   <= out_op_d;
      out_in1_q  <= out_in1_d;
      out_in2_q  <= out_in2_d;
      out_dest_q <= out_dest_d;
    end
  end

  assign out_op   = out_op_q;
  assign out_in1  = out_in1_q;
  assign out_in2  = out_in2_q;
  assign out_dest = out_dest_q;

endmodule
